// File: rtl/msrv32_pipe_reg_gen.sv
// rtl/msrv32_pipe_reg_gen.sv - elastic multi-slot pipeline register with stall, flush and capture bit-clear
module msrv32_pipe_reg_gen #(
   parameter int  DATA_W      = 32,
   parameter int  STAGES      = 1,
   parameter bit  CLR_BIT_EN  = 1'b1,
   parameter int  CLR_BIT_POS = 0,
   localparam int CNT_W       = $clog2(STAGES + 1)
) (
   input  logic              clk_in,
   input  logic              reset_n_in,
   input  logic              in_valid_in,
   output logic              in_ready_out,
   input  logic [DATA_W-1:0] in_data_in,
   input  logic              clr_bit_in,
   input  logic              stall_in,
   input  logic              flush_in,
   output logic              out_valid_out,
   input  logic              out_ready_in,
   output logic [DATA_W-1:0] out_data_out,
   output logic [CNT_W-1:0]  count_out
);

   logic [STAGES-1:0]             valid_q;
   logic [STAGES-1:0]             valid_d;
   logic [STAGES-1:0][DATA_W-1:0] data_q;
   logic [STAGES-1:0][DATA_W-1:0] data_d;
   logic [CNT_W-1:0]              count_q;
   logic [CNT_W-1:0]              count_d;

   logic [STAGES-1:0] advance;
   logic              hold;
   logic              in_rdy;
   logic              accept;
   logic              drain;
   logic [DATA_W-1:0] cap_data;

   assign hold = stall_in | flush_in;

   // Ready chain walked from the output back to slot 0 so a bubble anywhere collapses in one cycle
   always_comb begin
      logic rdy;
      advance = '0;
      rdy     = out_ready_in;
      for (int i = STAGES - 1; i >= 0; i--) begin
         advance[i] = valid_q[i] & rdy & ~hold;
         rdy        = ~valid_q[i] | advance[i];
      end
      in_rdy = rdy & ~hold;
   end

   assign in_ready_out  = in_rdy;
   assign accept        = in_valid_in & in_rdy;
   assign out_valid_out = valid_q[STAGES-1] & ~hold;
   assign drain         = out_valid_out & out_ready_in;
   assign out_data_out  = data_q[STAGES-1];
   assign count_out     = count_q;

   // Captured payload, optionally with the branch-target bit forced low
   always_comb begin
      cap_data = in_data_in;
      if (CLR_BIT_EN && clr_bit_in) begin
         cap_data[CLR_BIT_POS] = 1'b0;
      end
   end

   // Per-slot next state: draining clears valid, loading sets it, flush clears everything
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      for (int i = 0; i < STAGES; i++) begin
         if (advance[i]) begin
            valid_d[i] = 1'b0;
         end
      end
      if (accept) begin
         valid_d[0] = 1'b1;
         data_d[0]  = cap_data;
      end
      for (int i = 1; i < STAGES; i++) begin
         if (advance[i-1]) begin
            valid_d[i] = 1'b1;
            data_d[i]  = data_q[i-1];
         end
      end
      if (flush_in) begin
         valid_d = '0;
      end
   end

   // Occupancy tracks accepts minus drains; flush empties the pipe
   always_comb begin
      count_d = count_q + CNT_W'(accept) - CNT_W'(drain);
      if (flush_in) begin
         count_d = '0;
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         valid_q <= '0;
         data_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_msrv32_pipe_reg_gen.sv
// tb/tb_msrv32_pipe_reg_gen.sv - directed bench for msrv32_pipe_reg_gen
module tb_msrv32_pipe_reg_gen;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic        clr_bit;
   logic        stall;
   logic        flush;
   logic        out_ready;

   logic        in_ready_a;
   logic        out_valid_a;
   logic [31:0] out_data_a;
   logic [1:0]  count_a;
   logic        in_ready_b;
   logic        out_valid_b;
   logic [31:0] out_data_b;
   logic [1:0]  count_b;

   int vectors = 0;
   int errors  = 0;

   msrv32_pipe_reg_gen #(.DATA_W(32), .STAGES(3), .CLR_BIT_EN(1'b1), .CLR_BIT_POS(0)) u_dut (
      .clk_in        (clk),
      .reset_n_in    (rst_n),
      .in_valid_in   (in_valid),
      .in_ready_out  (in_ready_a),
      .in_data_in    (in_data),
      .clr_bit_in    (clr_bit),
      .stall_in      (stall),
      .flush_in      (flush),
      .out_valid_out (out_valid_a),
      .out_ready_in  (out_ready),
      .out_data_out  (out_data_a),
      .count_out     (count_a)
   );

   msrv32_pipe_reg_gen #(.DATA_W(32), .STAGES(3), .CLR_BIT_EN(1'b0), .CLR_BIT_POS(0)) u_dut_nc (
      .clk_in        (clk),
      .reset_n_in    (rst_n),
      .in_valid_in   (in_valid),
      .in_ready_out  (in_ready_b),
      .in_data_in    (in_data),
      .clr_bit_in    (clr_bit),
      .stall_in      (stall),
      .flush_in      (flush),
      .out_valid_out (out_valid_b),
      .out_ready_in  (out_ready),
      .out_data_out  (out_data_b),
      .count_out     (count_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic ov, input logic [31:0] od,
                            input logic [1:0] cnt);
      chk({tag, ".out_valid"}, {31'd0, out_valid_a}, {31'd0, ov});
      if (ov) chk({tag, ".out_data"}, out_data_a, od);
      chk({tag, ".count"}, {30'd0, count_a}, {30'd0, cnt});
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      clr_bit   = 1'b0;
      stall     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      #2;
      chk("rst.out_valid", {31'd0, out_valid_a}, 32'd0);
      chk("rst.out_data", out_data_a, 32'd0);
      chk("rst.count", {30'd0, count_a}, 32'd0);
      chk("rst.in_ready", {31'd0, in_ready_a}, 32'd1);
      #10;
      rst_n = 1'b1;
      tick();

      // 1: streaming with out_ready high
      in_valid = 1'b1; in_data = 32'h10; #1;
      chk("t1.in_ready", {31'd0, in_ready_a}, 32'd1);
      tick(); chk_state("t1.e1", 1'b0, 32'h0, 2'd1);
      in_data = 32'h11; tick(); chk_state("t1.e2", 1'b0, 32'h0, 2'd2);
      in_data = 32'h12; tick();
      in_valid = 1'b0; #1;
      chk_state("t1.e3", 1'b1, 32'h10, 2'd3);
      tick(); chk_state("t1.e4", 1'b1, 32'h11, 2'd2);
      tick(); chk_state("t1.e5", 1'b1, 32'h12, 2'd1);
      tick(); chk_state("t1.e6", 1'b0, 32'h0, 2'd0);

      // 2: fill under backpressure, then full-rate flow at full occupancy
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h20; tick();
      in_data = 32'h21; tick();
      in_data = 32'h22; tick();
      in_data = 32'h23; #1;
      chk("t2.full.in_ready", {31'd0, in_ready_a}, 32'd0);
      chk_state("t2.full", 1'b1, 32'h20, 2'd3);
      tick(); chk_state("t2.held", 1'b1, 32'h20, 2'd3);
      out_ready = 1'b1; #1;
      chk("t2.drain.in_ready", {31'd0, in_ready_a}, 32'd1);
      tick(); chk_state("t2.f1", 1'b1, 32'h21, 2'd3);
      in_data = 32'h24; tick(); chk_state("t2.f2", 1'b1, 32'h22, 2'd3);
      in_data = 32'h25; tick(); chk_state("t2.f3", 1'b1, 32'h23, 2'd3);
      in_valid = 1'b0;
      tick(); chk_state("t2.d1", 1'b1, 32'h24, 2'd2);
      tick(); chk_state("t2.d2", 1'b1, 32'h25, 2'd1);
      tick(); chk_state("t2.d3", 1'b0, 32'h0, 2'd0);

      // 3: capture bit-clear, honoured only when enabled
      in_valid = 1'b1; clr_bit = 1'b1; in_data = 32'h8000_0005; tick();
      clr_bit = 1'b0; in_data = 32'h0000_0007; tick();
      in_valid = 1'b0; tick();
      chk_state("t3.clr", 1'b1, 32'h8000_0004, 2'd2);
      chk("t3.noclr.valid", {31'd0, out_valid_b}, 32'd1);
      chk("t3.noclr.data", out_data_b, 32'h8000_0005);
      tick();
      chk_state("t3.next", 1'b1, 32'h0000_0007, 2'd1);
      tick(); chk_state("t3.empty", 1'b0, 32'h0, 2'd0);

      // 4: flush with two beats held and a beat offered
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h30; tick();
      in_data = 32'h31; tick();
      chk("t4.pre.count", {30'd0, count_a}, 32'd2);
      in_data = 32'hAA; flush = 1'b1; out_ready = 1'b1; #1;
      chk("t4.flush.out_valid", {31'd0, out_valid_a}, 32'd0);
      chk("t4.flush.in_ready", {31'd0, in_ready_a}, 32'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk_state("t4.post", 1'b0, 32'h0, 2'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_state("t4.quiet", 1'b0, 32'h0, 2'd0);
      end

      // 5: stall for four cycles with two beats in flight
      in_valid = 1'b1; in_data = 32'h40; tick();
      in_data = 32'h41; tick();
      stall = 1'b1; in_data = 32'h42; #1;
      for (int k = 0; k < 4; k++) begin
         chk("t5.stall.in_ready", {31'd0, in_ready_a}, 32'd0);
         chk_state("t5.stall", 1'b0, 32'h0, 2'd2);
         tick();
      end
      stall = 1'b0; #1;
      chk("t5.rel.in_ready", {31'd0, in_ready_a}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk_state("t5.o1", 1'b1, 32'h40, 2'd3);
      tick(); chk_state("t5.o2", 1'b1, 32'h41, 2'd2);
      tick(); chk_state("t5.o3", 1'b1, 32'h42, 2'd1);
      tick(); chk_state("t5.o4", 1'b0, 32'h0, 2'd0);

      // 6: asynchronous reset while full, then clean resumption
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h50; tick();
      in_data = 32'h51; tick();
      in_data = 32'h52; tick();
      in_valid = 1'b0;
      chk_state("t6.full", 1'b1, 32'h50, 2'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6.rst.count", {30'd0, count_a}, 32'd0);
      chk("t6.rst.out_valid", {31'd0, out_valid_a}, 32'd0);
      chk("t6.rst.out_data", out_data_a, 32'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'h60;
      tick();
      in_valid = 1'b0;
      chk_state("t6.r1", 1'b0, 32'h0, 2'd1);
      tick(); tick();
      chk_state("t6.r3", 1'b1, 32'h60, 2'd1);
      tick(); chk_state("t6.r4", 1'b0, 32'h0, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
